lt24_touch_scanner: RTL and testbench
=====================================

LT24_TOUCH_SCANNER -- requirements
Module: lt24_touch_scanner

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 500000, meaning clk cycles between touch scans (10 ms at 50 MHz).
REQ-002 SHALL have parameter RX_TIMEOUT, default 65535, meaning the maximum clk cycles to wait for a received byte.
REQ-003 SHALL have parameter CMD_X, default 8'hD0, meaning the controller command byte for an X conversion (12-bit, differential, PENIRQ enabled).
REQ-004 SHALL have parameter CMD_Y, default 8'h90, meaning the controller command byte for a Y conversion.
REQ-005 SHALL have port clk, input, 1 bit: system clock.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port pen_irq_n, input, 1 bit: touch-controller pen interrupt, asynchronous, low = pen down.
REQ-008 SHALL have port spi_select, output, 1 bit: SPI master port select.
REQ-009 SHALL have port mem_addr, output, 3 bits: SPI master register address.
REQ-010 SHALL have port write_n, output, 1 bit: SPI master write strobe, active-low.
REQ-011 SHALL have port read_n, output, 1 bit: SPI master read strobe, active-low.
REQ-012 SHALL have port data_from_cpu, output, 16 bits: write data to the SPI master.
REQ-013 SHALL have port data_to_cpu, input, 16 bits: registered read data from the SPI master.
REQ-014 SHALL have port dataavailable, input, 1 bit: SPI master RRDY.
REQ-015 SHALL have port x_pos, output, 12 bits: last published X sample.
REQ-016 SHALL have port y_pos, output, 12 bits: last published Y sample.
REQ-017 SHALL have port pos_valid, output, 1 bit: one-cycle pulse when x_pos and y_pos update.
REQ-018 SHALL have port touched, output, 1 bit: synchronized pen-down level.
REQ-019 SHALL have port busy, output, 1 bit: scan frame in progress.
REQ-020 SHALL have port timeout_err, output, 1 bit: sticky flag, set on RX timeout.

Function
REQ-021 SHALL synchronize pen_irq_n through two flops; touched = inverted synchronizer output.
REQ-022 SHALL perform each bus access as exactly 2 cycles with spi_select=1, the strobe low, and address/data stable, followed by at least 1 idle cycle (spi_select=0, write_n=read_n=1).
REQ-023 SHALL sample data_to_cpu on the 2nd cycle of a read access.
REQ-024 SHALL hold data_from_cpu=0 and mem_addr=0 when idle.
REQ-025 SHALL use FSM states INIT, IDLE, SS_ON, TX, WAIT_RX, RX, SS_OFF, PUBLISH.
REQ-026 SHALL in INIT write 16'h0001 to address 5 (slave select), then go to IDLE; this occurs once after reset.
REQ-027 SHALL run a free-running tick counter from 0 to SAMPLE_DIV-1 that wraps to 0; tick asserts at the wrap.
REQ-028 SHALL in IDLE, on tick with touched=1, go to SS_ON and set busy=1; SHALL ignore a tick with touched=0.
REQ-029 SHALL in SS_ON write 16'h0400 (SSO) to address 3, then go to TX.
REQ-030 SHALL transmit a 6-byte frame: CMD_X, 8'h00, 8'h00, CMD_Y, 8'h00, 8'h00.
REQ-031 SHALL in TX write {8'h00, byte} to address 1, then go to WAIT_RX.
REQ-032 SHALL in WAIT_RX wait for dataavailable=1 and then go to RX.
REQ-033 SHALL in RX read address 0 (clearing RRDY), store bits [7:0], then go to TX for the next byte, or to SS_OFF after byte 6.
REQ-034 SHALL assemble each 12-bit result as {rx1[6:0], rx2[7:3]}, where rx1 and rx2 are the 2nd and 3rd bytes of that axis.
REQ-035 SHALL in SS_OFF write 16'h0000 to address 3, then go to PUBLISH.
REQ-036 SHALL in PUBLISH update x_pos and y_pos, pulse pos_valid for 1 cycle, clear busy, and return to IDLE.
REQ-037 SHALL complete and publish the frame even if the pen is released mid-frame.
REQ-038 SHALL NOT queue a tick that occurs while busy=1; that tick is dropped.
REQ-039 SHALL count cycles in WAIT_RX; on reaching RX_TIMEOUT it SHALL set timeout_err, skip the remaining bytes, go to SS_OFF, then return to IDLE without pos_valid and without updating x_pos or y_pos.
REQ-040 SHALL clear timeout_err only by reset.
REQ-041 SHALL have no explicit handling for dataavailable already set at TX time; the RX read clears it, and the SPI master's ROE flag is not monitored.

Reset
REQ-042 SHALL on reset_n=0, asynchronously force: state INIT; x_pos=0, y_pos=0, pos_valid=0, busy=0, timeout_err=0; spi_select=0, write_n=1, read_n=1, mem_addr=0, data_from_cpu=0; tick counter=0; synchronizer flops=1 (touched=0).
REQ-043 SHALL abandon any in-progress access or frame on reset mid-frame, and re-run INIT after release.

Verification
REQ-044 Release reset -> first access is a 2-cycle write, addr 5, data 16'h0001; then the bus stays idle while pen_irq_n=1.
REQ-045 SAMPLE_DIV=100, pen_irq_n=0, SPI model returning bytes 00,7F,F8,00,40,00 -> access order is addr3 0x0400, six TX/RX pairs with TX data D0,00,00,90,00,00, then addr3 0x0000; pos_valid pulses once; x_pos=12'hFFF, y_pos=12'h800.
REQ-046 Pen released after byte 2 of a frame -> frame completes and pos_valid pulses; the next tick starts no frame.
REQ-047 RX_TIMEOUT=50, model never asserts dataavailable after byte 1 -> timeout_err=1 after 50 cycles, addr3 written 0x0000, no pos_valid, x_pos/y_pos unchanged, and the next frame runs normally.
REQ-048 Assert reset_n=0 during WAIT_RX of byte 4 -> all outputs take their reset values immediately; after release, INIT's addr-5 write occurs before any frame.
REQ-049 Tick arriving while busy=1 (SAMPLE_DIV smaller than frame length) -> tick ignored, no overlapping frame, and every access is followed by an idle cycle.

Source files
------------

// File: rtl/lt24_touch_scanner.sv
// Periodic LT24 touch-controller scanner that drives an SPI master through its register bus.
// Each scan sends a 6-byte X/Y conversion frame and publishes the 12-bit coordinates.
module lt24_touch_scanner #(
  parameter int unsigned SAMPLE_DIV = 500000,
  parameter int unsigned RX_TIMEOUT = 65535,
  parameter logic [7:0]  CMD_X      = 8'hD0,
  parameter logic [7:0]  CMD_Y      = 8'h90
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pen_irq_n,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic        write_n,
  output logic        read_n,
  output logic [15:0] data_from_cpu,
  input  logic [15:0] data_to_cpu,
  input  logic        dataavailable,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        pos_valid,
  output logic        touched,
  output logic        busy,
  output logic        timeout_err
);
  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned WAIT_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  typedef enum logic [2:0] {INIT, IDLE, SS_ON, TX, WAIT_RX, RX, SS_OFF, PUBLISH} state_t;

  state_t            state, state_next;
  logic [1:0]        phase, phase_next;
  logic [2:0]        byte_idx, byte_next;
  logic [6:0]        rx_x1, rx_x1_next, rx_y1, rx_y1_next;
  logic [4:0]        rx_x2, rx_x2_next, rx_y2, rx_y2_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [DIV_W-1:0]  tick_cnt;
  logic              tick;
  logic              abort, abort_next, busy_next, terr_next, valid_next;
  logic [11:0]       x_next, y_next;
  logic [1:0]        pen_sync;
  logic              access, rd;
  logic [2:0]        addr;
  logic [15:0]       wdata;
  logic [7:0]        tx_byte;
  logic [7:0]        unused_rx_hi;

  assign unused_rx_hi = data_to_cpu[15:8];
  assign touched      = ~pen_sync[1];
  assign tick         = (tick_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pen_sync <= 2'b11;
      tick_cnt <= '0;
    end else begin
      pen_sync <= {pen_sync[0], pen_irq_n};
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  always_comb begin
    case (byte_idx)
      3'd0:    tx_byte = CMD_X;
      3'd3:    tx_byte = CMD_Y;
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT;
      phase       <= '0;
      byte_idx    <= '0;
      rx_x1       <= '0;
      rx_x2       <= '0;
      rx_y1       <= '0;
      rx_y2       <= '0;
      wait_cnt    <= '0;
      abort       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      pos_valid   <= 1'b0;
    end else begin
      state       <= state_next;
      phase       <= phase_next;
      byte_idx    <= byte_next;
      rx_x1       <= rx_x1_next;
      rx_x2       <= rx_x2_next;
      rx_y1       <= rx_y1_next;
      rx_y2       <= rx_y2_next;
      wait_cnt    <= wait_next;
      abort       <= abort_next;
      busy        <= busy_next;
      timeout_err <= terr_next;
      x_pos       <= x_next;
      y_pos       <= y_next;
      pos_valid   <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    byte_next  = byte_idx;
    rx_x1_next = rx_x1;
    rx_x2_next = rx_x2;
    rx_y1_next = rx_y1;
    rx_y2_next = rx_y2;
    wait_next  = wait_cnt;
    abort_next = abort;
    busy_next  = busy;
    terr_next  = timeout_err;
    x_next     = x_pos;
    y_next     = y_pos;
    valid_next = 1'b0;
    access     = 1'b0;
    rd         = 1'b0;
    addr       = '0;
    wdata      = '0;

    case (state)
      INIT:    begin access = 1'b1; addr = 3'd5; wdata = 16'h0001; end
      IDLE:    if (tick && touched) begin
                 state_next = SS_ON;
                 busy_next  = 1'b1;
                 byte_next  = '0;
                 abort_next = 1'b0;
               end
      SS_ON:   begin access = 1'b1; addr = 3'd3; wdata = 16'h0400; end
      TX:      begin access = 1'b1; addr = 3'd1; wdata = {8'h00, tx_byte}; end
      WAIT_RX: begin
        if (dataavailable) begin
          state_next = RX;
          wait_next  = '0;
        end else if (wait_cnt == WAIT_W'(RX_TIMEOUT - 1)) begin
          state_next = SS_OFF;
          wait_next  = '0;
          terr_next  = 1'b1;
          abort_next = 1'b1;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      RX:      begin access = 1'b1; rd = 1'b1; end
      SS_OFF:  begin access = 1'b1; addr = 3'd3; end
      PUBLISH: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        valid_next = 1'b1;
        x_next     = {rx_x1, rx_x2};
        y_next     = {rx_y1, rx_y2};
      end
      default: state_next = INIT;
    endcase

    // Access phase 0 is the idle/setup cycle, phases 1-2 drive the strobe; leaving phase 2
    // always passes through phase 0 of the next state, which guarantees the idle gap.
    if (access) begin
      phase_next = phase + 2'd1;
      if (phase == 2'd2) begin
        phase_next = '0;
        case (state)
          INIT:  state_next = IDLE;
          SS_ON: state_next = TX;
          TX:    state_next = WAIT_RX;
          RX: begin
            case (byte_idx)
              3'd1:    rx_x1_next = data_to_cpu[6:0];
              3'd2:    rx_x2_next = data_to_cpu[7:3];
              3'd4:    rx_y1_next = data_to_cpu[6:0];
              3'd5:    rx_y2_next = data_to_cpu[7:3];
              default: ;
            endcase
            if (byte_idx == 3'd5) begin
              state_next = SS_OFF;
            end else begin
              byte_next  = byte_idx + 3'd1;
              state_next = TX;
            end
          end
          SS_OFF: if (abort) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                  end else begin
                    state_next = PUBLISH;
                  end
          default: ;
        endcase
      end
    end

    spi_select    = access && (phase != 2'd0);
    write_n       = ~(spi_select && !rd);
    read_n        = ~(spi_select && rd);
    mem_addr      = spi_select ? addr : '0;
    data_from_cpu = (spi_select && !rd) ? wdata : '0;
  end
endmodule

// File: tb/tb_lt24_touch_scanner.sv
// Bench for lt24_touch_scanner: an SPI-master model answers TX bytes, and a frame-level
// scoreboard predicts the bus access sequence and the published coordinates.
module tb_lt24_touch_scanner;
  localparam int unsigned DIV = 40;
  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pen_irq_n;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        write_n;
  logic        read_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        dataavailable;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        pos_valid;
  logic        touched;
  logic        busy;
  logic        timeout_err;

  lt24_touch_scanner #(.SAMPLE_DIV(DIV), .RX_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .pen_irq_n(pen_irq_n),
    .spi_select(spi_select), .mem_addr(mem_addr), .write_n(write_n), .read_n(read_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .dataavailable(dataavailable),
    .x_pos(x_pos), .y_pos(y_pos), .pos_valid(pos_valid), .touched(touched),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc, acc_count, pv_count, run_len, base;
  int frame_tx, frame_answered, frame_mute, last_tx_end;
  int mute_next = 6;
  bit use_fixed = 1'b0;
  logic [7:0]  frame_bytes [6];
  logic [7:0]  fixed_bytes [6] = '{8'h00, 8'h7F, 8'hF8, 8'h00, 8'h40, 8'h00};
  logic [11:0] frame_x, frame_y, last_x, last_y;
  logic [19:0] exp_acc [$];
  logic [23:0] exp_xy [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic r, input logic [2:0] a, input logic [15:0] d);
    return {r, a, d};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame();
    int b1, b2, b4, b5;
    for (int i = 0; i < 6; i++) frame_bytes[i] = use_fixed ? fixed_bytes[i] : 8'($urandom);
    use_fixed      = 1'b0;
    frame_mute     = mute_next;
    mute_next      = 6;
    frame_tx       = 0;
    frame_answered = 0;
    b1 = frame_bytes[1]; b2 = frame_bytes[2]; b4 = frame_bytes[4]; b5 = frame_bytes[5];
    frame_x = 12'((b1 % 128) * 32 + b2 / 8);
    frame_y = 12'((b4 % 128) * 32 + b5 / 8);
    for (int i = 0; i < 6; i++) begin
      exp_acc.push_back(mk(1'b0, 3'd1, (i == 0) ? 16'h00D0 : (i == 3) ? 16'h0090 : 16'h0000));
      exp_acc.push_back(mk(1'b1, 3'd0, 16'h0000));
    end
    exp_acc.push_back(mk(1'b0, 3'd3, 16'h0000));
  endtask

  task automatic run_monitor();
    logic [20:0] cur;
    logic [19:0] obs, exp;
    logic [23:0] e;
    int bad, start, ti, resp_delay;
    bit resp_pending;
    logic [7:0] resp_byte;
    resp_pending = 1'b0; resp_delay = 0; resp_byte = '0; bad = 0; start = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run_len = 0; bad = 0; resp_pending = 1'b0; dataavailable = 1'b0;
        exp_acc.delete(); exp_acc.push_back(mk(1'b0, 3'd5, 16'h0001));
        exp_xy.delete(); last_x = '0; last_y = '0; cyc = 0; base = -1;
        frame_tx = 0; frame_answered = 0; frame_mute = 6; mute_next = 6;
        continue;
      end
      cyc++;
      if (spi_select === 1'b1) begin
        if (run_len == 0) begin
          cur   = {~read_n, ~write_n, mem_addr, data_from_cpu};
          start = cyc;
          check("busy_in_access", busy,
                (exp_acc.size() != 0 && exp_acc[0][18:16] == 3'd5) ? 32'd0 : 32'd1);
        end else if ({~read_n, ~write_n, mem_addr, data_from_cpu} !== cur) begin
          bad = 1;
        end
        if ((read_n ^ write_n) !== 1'b1) bad = 1;
        run_len++;
      end else if (run_len != 0) begin
        check("access_len", run_len, 2);
        check("access_stable", bad, 0);
        check("idle_bus", {write_n, read_n, mem_addr, data_from_cpu}, {2'b11, 19'd0});
        obs = {cur[20], cur[18:16], cur[20] ? 16'h0000 : cur[15:0]};
        if (exp_acc.size() == 0) begin
          exp = mk(1'b0, 3'd3, 16'h0400);
          start_frame();
          if (base < 0) base = start;
          else check("tick_align", (start - base) % DIV, 0);
        end else begin
          exp = exp_acc.pop_front();
        end
        check("access", obs, exp);
        if (obs[19:16] == 4'b0001) begin
          ti = frame_tx;
          frame_tx++;
          last_tx_end = cyc;
          if (ti < frame_mute && ti < 6) begin
            resp_pending = 1'b1;
            resp_delay   = $urandom_range(0, 4);
            resp_byte    = frame_bytes[ti];
          end else begin
            while (exp_acc.size() > 1) void'(exp_acc.pop_front());
          end
        end else if (obs[19] == 1'b1) begin
          dataavailable = 1'b0;
          frame_answered++;
        end else if (obs == mk(1'b0, 3'd3, 16'h0000) && frame_answered == 6) begin
          exp_xy.push_back({frame_x, frame_y});
        end
        acc_count++;
        run_len = 0;
        bad = 0;
      end
      if (pos_valid === 1'b1) begin
        check("pv_expected", exp_xy.size() != 0, 1);
        if (exp_xy.size() != 0) begin
          e = exp_xy.pop_front();
          check("x_pos", x_pos, e[23:12]);
          check("y_pos", y_pos, e[11:0]);
          last_x = e[23:12];
          last_y = e[11:0];
        end
        pv_count++;
      end
      if (resp_pending) begin
        if (resp_delay == 0) begin
          dataavailable = 1'b1;
          data_to_cpu   = {8'($urandom), resp_byte};
          resp_pending  = 1'b0;
        end else begin
          resp_delay--;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus"}, {spi_select, write_n, read_n, mem_addr, data_from_cpu}, {3'b011, 19'd0});
    check({tag, "_pos"}, {x_pos, y_pos}, 24'd0);
    check({tag, "_flags"}, {pos_valid, busy, timeout_err, touched}, 4'b0000);
  endtask

  initial begin
    int n, pvs, d, acc0;
    reset_n = 1'b0; pen_irq_n = 1'b1; dataavailable = 1'b0; data_to_cpu = '0;
    acc_count = 0; pv_count = 0; run_len = 0;
    fork
      run_monitor();
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) tick();
    check_reset_outputs("reset0");
    @(negedge clk); #2 reset_n = 1'b1;

    // INIT write then quiet bus while the pen is up
    n = 0;
    while (acc_count < 1 && n < 20) begin tick(); n++; end
    check("init_access_seen", acc_count, 1);
    repeat (150) tick();
    check("idle_no_access", acc_count, 1);
    check("idle_busy", busy, 0);

    // Fixed-byte frame with known coordinates
    use_fixed = 1'b1;
    pen_irq_n = 1'b0;
    repeat (3) tick();
    check("touched_high", touched, 1);
    n = 0;
    while (pv_count < 1 && n < 300) begin tick(); n++; end
    check("fixed_pv", pv_count, 1);
    check("fixed_x", x_pos, 12'hFFF);
    check("fixed_y", y_pos, 12'h800);

    // Random frames back to back (ticks land while busy)
    n = 0;
    while (pv_count < 5 && n < 800) begin tick(); n++; end
    check("random_frames", pv_count, 5);
    check("no_timeout_yet", timeout_err, 0);

    // Pen released after byte 2 of a frame
    n = 0;
    while (!(frame_answered == 2 && frame_tx == 2) && n < 300) begin tick(); n++; end
    check("release_point", frame_answered, 2);
    pen_irq_n = 1'b1;
    pvs = pv_count;
    n = 0;
    while (pv_count < pvs + 1 && n < 300) begin tick(); n++; end
    check("release_frame_done", pv_count, pvs + 1);
    acc0 = acc_count;
    repeat (3 * DIV) tick();
    check("release_no_new_frame", acc_count, acc0);
    check("release_touched", touched, 0);
    check("release_busy", busy, 0);

    // RX timeout after byte 1
    mute_next = 1;
    pvs = pv_count;
    pen_irq_n = 1'b0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 400) begin tick(); n++; end
    check("timeout_set", timeout_err, 1);
    d = cyc - last_tx_end;
    check("timeout_delay", (d >= int'(TMO) && d <= int'(TMO) + 2), 1);
    n = 0;
    while (!(exp_acc.size() == 0 && run_len == 0) && n < 20) begin tick(); n++; end
    check("timeout_ss_off", exp_acc.size(), 0);
    repeat (2) tick();
    check("timeout_no_pv", pv_count, pvs);
    check("timeout_pos_kept", {x_pos, y_pos}, {last_x, last_y});
    n = 0;
    while (pv_count < pvs + 1 && n < 300) begin tick(); n++; end
    check("after_timeout_frame", pv_count, pvs + 1);
    check("timeout_sticky", timeout_err, 1);

    // Reset during WAIT_RX of byte 4
    mute_next = 3;
    n = 0;
    while (!(frame_mute == 3 && frame_tx == 4) && n < 400) begin tick(); n++; end
    check("reset_point", frame_tx, 4);
    repeat (5) tick();
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    repeat (3) tick();
    @(negedge clk); #2 reset_n = 1'b1;
    pvs = pv_count;
    n = 0;
    while (pv_count < pvs + 1 && n < 400) begin tick(); n++; end
    check("post_reset_frame", pv_count, pvs + 1);
    check("post_reset_tmo_clear", timeout_err, 0);

    pen_irq_n = 1'b1;
    repeat (150) tick();
    check("drain_xy", exp_xy.size(), 0);
    check("drain_acc", exp_acc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
